// File: rtl/seq_chunk_adder.sv
`default_nettype none
// ============================================================================
//  Module   : seq_chunk_adder
//  Purpose  : Multi-cycle N-bit adder/subtractor that processes K bits per
//             clock, LSB chunk first, rippling the carry through a register.
//             Completion is flagged by a one-cycle done pulse. The sum and
//             carry-out are registered and only update on completion.
//  Ports    : clk    - rising-edge clock
//             rst    - asynchronous active-high reset
//             start  - request, accepted in IDLE or DONE, ignored in RUN
//             a, b   - N-bit operands, captured with start
//             cin    - carry-in for add; ignored for subtract
//             sub    - 0 = a + b + cin, 1 = a - b
//             busy   - high while chunks are being processed
//             done   - one-cycle completion pulse
//             sum    - registered N-bit result
//             cout   - registered carry-out (for subtract, 1 = no borrow)
//             ovf    - registered signed overflow (only with the macro)
//  Options  : `define SEQ_CHUNK_ADDER_OVF_EN adds the ovf output.
//  Revision : 1.0 - initial release
// ============================================================================
module seq_chunk_adder #(
  parameter int N = 16,
  parameter int K = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  input  logic         sub,
  output logic         busy,
  output logic         done,
`ifdef SEQ_CHUNK_ADDER_OVF_EN
  output logic         ovf,
`endif
  output logic [N-1:0] sum,
  output logic         cout
);

  localparam int c_M     = N / K;
  localparam int c_CNT_W = (c_M > 1) ? $clog2(c_M) : 1;
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(c_M - 1);

  generate
    if ((N % K) != 0) begin : g_param_check
      $error("seq_chunk_adder: N must be a multiple of K");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_next;

  logic [N-1:0]         r_a;      // operand A, shifted right one chunk per RUN edge
  logic [N-1:0]         r_b;      // operand B (already inverted for subtract)
  logic [N-1:0]         r_acc;    // partial result, filled from the top down
  logic                 r_carry;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [N-1:0]         r_sum;
  logic                 r_cout;
`ifdef SEQ_CHUNK_ADDER_OVF_EN
  logic                 r_ovf;
  logic                 w_ovf;
`endif

  logic [K:0]           w_chunk;
  logic [N-1:0]         w_acc_next;
  logic                 w_last;
  logic                 w_load;

  // The current chunk always sits in the low K bits of the shifted operands.
  assign w_chunk    = {1'b0, r_a[K-1:0]} + {1'b0, r_b[K-1:0]} + (K+1)'(r_carry);
  // New chunk enters at the top; after M shifts the LSB chunk reaches bit 0.
  assign w_acc_next = (N'(w_chunk[K-1:0]) << (N - K)) | (r_acc >> K);
  assign w_last     = (r_cnt == c_LAST);
  assign w_load     = start && (r_state != S_RUN);

`ifdef SEQ_CHUNK_ADDER_OVF_EN
  // Carry into the MSB is recovered as a^b^s at that bit, then XORed with
  // the carry out of it.
  assign w_ovf = r_a[K-1] ^ r_b[K-1] ^ w_chunk[K-1] ^ w_chunk[K];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = start ? S_RUN : S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
`ifdef SEQ_CHUNK_ADDER_OVF_EN
      r_ovf   <= 1'b0;
`endif
    end else if (w_load) begin
      r_a     <= a;
      r_b     <= b ^ {N{sub}};
      r_carry <= sub ? 1'b1 : cin;
      r_cnt   <= '0;
    end else if (r_state == S_RUN) begin
      r_a     <= r_a >> K;
      r_b     <= r_b >> K;
      r_carry <= w_chunk[K];
      r_acc   <= w_acc_next;
      r_cnt   <= r_cnt + c_CNT_W'(1);
      if (w_last) begin
        r_sum  <= w_acc_next;
        r_cout <= w_chunk[K];
`ifdef SEQ_CHUNK_ADDER_OVF_EN
        r_ovf  <= w_ovf;
`endif
      end
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;
`ifdef SEQ_CHUNK_ADDER_OVF_EN
  assign ovf  = r_ovf;
`endif

endmodule
`default_nettype wire
